// File: rtl/mpadd_pkg.sv
// Shared types and helpers for the chunked multi-precision adder/subtractor.
package mpadd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of CHUNK-wide slices needed to cover a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/mp_chunk_adder.sv
// One CHUNK-bit slice adder with carry in/out; shared by both passes.
module mp_chunk_adder #(
  parameter int unsigned CHUNK = 104
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);

endmodule

// File: rtl/mpadder_chunked.sv
// Multi-precision add/subtract resolved one CHUNK slice per cycle through a registered carry.
// MPADD_CONDCORR_EN adds a second pass for modular correction (S-M after add, S+M after borrow).
module mpadder_chunked
  import mpadd_pkg::*;
#(
  parameter int unsigned WIDTH = 514,
  parameter int unsigned CHUNK = 104
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             reduced
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned LAST   = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef logic [NCHUNK-1:0][CHUNK-1:0] slices_t;

  state_t           r_state, w_next;
  logic             w_accept, w_last;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_mode;
  logic [KW-1:0]    r_k;
  logic             r_carry, r_carry1;
  slices_t          r_s;
  logic [PW-1:0]    w_s_flat;
  logic [WIDTH-1:0] w_b_mux;
  slices_t          w_a_sl, w_b_sl;
  logic [CHUNK-1:0] w_op_a, w_op_b, w_sum;
  logic             w_cout, w_cout_last, w_carry_next;
  logic [WIDTH-1:0] w_result_sel;

  assign w_s_flat = r_s;
  assign w_b_mux  = (r_mode == MODE_ADD) ? r_b : ~r_b;
  assign w_a_sl   = PW'(r_a);
  assign w_b_sl   = PW'(w_b_mux);
  assign w_last   = (r_k == KW'(NCHUNK - 1));

`ifdef MPADD_CONDCORR_EN
  logic [WIDTH-1:0] r_m;
  slices_t          r_d;
  logic             r_carry2;
  logic [PW-1:0]    w_d_flat;
  logic [WIDTH-1:0] w_m_mux;
  slices_t          w_s_sl, w_m_sl;
  logic             w_reduced_sel;

  assign w_d_flat      = r_d;
  assign w_m_mux       = (r_mode == MODE_ADD) ? ~r_m : r_m;
  assign w_s_sl        = PW'(w_s_flat[WIDTH-1:0]);
  assign w_m_sl        = PW'(w_m_mux);
  assign w_reduced_sel = (r_mode == MODE_ADD) ? (r_carry1 | r_carry2) : ~r_carry1;
  assign w_result_sel  = w_reduced_sel ? w_d_flat[WIDTH-1:0] : w_s_flat[WIDTH-1:0];

  if (PW > WIDTH) begin : g_d_pad
    logic w_unused_d_pad;
    assign w_unused_d_pad = ^w_d_flat[PW-1:WIDTH];
  end
`else
  logic w_unused_m;
  assign w_unused_m   = ^in_m;
  assign w_result_sel = w_s_flat[WIDTH-1:0];
  assign reduced      = 1'b0;
`endif

  if (PW > WIDTH) begin : g_s_pad
    logic w_unused_s_pad;
    assign w_unused_s_pad = ^w_s_flat[PW-1:WIDTH];
  end

  // Carry out of bit WIDTH: in a short last slice it lands inside the sum, not at cout.
  if (LAST == CHUNK) begin : g_full_last
    assign w_cout_last = w_cout;
  end else begin : g_part_last
    assign w_cout_last = w_sum[LAST];
  end
  assign w_carry_next = w_last ? w_cout_last : w_cout;

  always_comb begin : p_opmux
    w_op_a = w_a_sl[r_k];
    w_op_b = w_b_sl[r_k];
`ifdef MPADD_CONDCORR_EN
    if (r_state == PASS2) begin
      w_op_a = w_s_sl[r_k];
      w_op_b = w_m_sl[r_k];
    end
`endif
  end

  mp_chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a    (w_op_a),
    .b    (w_op_b),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge resetn) begin : p_state
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin : p_next
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = PASS1;
          w_accept = 1'b1;
        end
      end
      PASS1: begin
        if (w_last) begin
`ifdef MPADD_CONDCORR_EN
          w_next = PASS2;
`else
          w_next = DONE;
`endif
        end
      end
      PASS2: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_accept = start;
        w_next   = start ? PASS1 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin : p_data
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_k      <= '0;
      r_carry  <= 1'b0;
      r_carry1 <= 1'b0;
      r_s      <= '0;
`ifdef MPADD_CONDCORR_EN
      r_m      <= '0;
      r_d      <= '0;
      r_carry2 <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
`ifdef MPADD_CONDCORR_EN
      r_m     <= in_m;
`endif
      r_mode  <= mode;
      r_k     <= '0;
      r_carry <= (mode == MODE_SUB);
    end else if (r_state == PASS1) begin
      r_s[r_k] <= w_sum;
      r_carry  <= w_carry_next;
      if (w_last) begin
        r_k      <= '0;
        r_carry1 <= w_carry_next;
`ifdef MPADD_CONDCORR_EN
        // Correction after add is S + ~M + 1; after subtract it is S + M.
        r_carry  <= (r_mode == MODE_ADD);
`endif
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
`ifdef MPADD_CONDCORR_EN
    else if (r_state == PASS2) begin
      r_d[r_k] <= w_sum;
      r_carry  <= w_carry_next;
      if (w_last) begin
        r_k      <= '0;
        r_carry2 <= w_carry_next;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
`endif
  end

  // Outputs trail the state by one cycle; the result is captured as DONE is left.
  always_ff @(posedge clk or negedge resetn) begin : p_out
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef MPADD_CONDCORR_EN
      reduced   <= 1'b0;
`endif
    end else begin
      busy <= (r_state == PASS1) || (r_state == PASS2);
      done <= (r_state == DONE);
      if (r_state == DONE) begin
        result    <= w_result_sel;
        carry_out <= r_carry1;
`ifdef MPADD_CONDCORR_EN
        reduced   <= w_reduced_sel;
`endif
      end
    end
  end

endmodule
